// File: rtl/voice_allocator.sv
// voice_allocator: round-robin allocation of 8 held keys onto 4 voices with LRU stealing
module voice_allocator #(
    parameter int STEAL_GAP = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        Enable,
    input  logic [7:0]  keys,
    output logic [3:0]  voice_on,
    output logic [11:0] voice_key,
    output logic        steal,
    output logic        all_busy
);
    typedef enum logic {SCAN, GAP} state_t;
    typedef logic [3:0][1:0] rank_t;

    state_t          r_state, w_state;
    logic [3:0]      r_on, w_on;
    logic [3:0][2:0] r_vkey, w_vkey;
    rank_t           r_rank, w_rank;
    logic [2:0]      r_idx, w_idx;
    logic [3:0]      r_cnt, w_cnt;
    logic [1:0]      r_victim, w_victim;
    logic            r_steal, w_steal;
    logic            r_all_busy, w_all_busy;
    logic [3:0]      w_match;
    logic [1:0]      w_hit_v, w_free_v, w_oldest;
    logic            w_key;

    // Promote voice v to newest; everything newer than it ages by one so ranks stay a permutation
    function automatic rank_t lru_touch(input rank_t rank, input logic [1:0] v);
        lru_touch = rank;
        for (int i = 0; i < 4; i++)
            if (rank[i] > rank[v]) lru_touch[i] = rank[i] - 2'd1;
        lru_touch[v] = 2'd3;
    endfunction

    // Per-voice lookups for the key under the scanner: owning voice, lowest free voice, oldest voice
    always_comb begin
        w_key    = keys[r_idx];
        w_match  = '0;
        w_hit_v  = '0;
        w_free_v = '0;
        w_oldest = '0;
        for (int v = 3; v >= 0; v--) begin
            w_match[v] = r_on[v] && (r_vkey[v] == r_idx);
            if (w_match[v]) w_hit_v = 2'(v);
            if (!r_on[v]) w_free_v = 2'(v);
            if (r_rank[v] == 2'd0) w_oldest = 2'(v);
        end
    end

    // Next-state and next-output logic; Enable low clears gates and parks the FSM in SCAN
    always_comb begin
        w_state  = r_state;
        w_on     = r_on;
        w_vkey   = r_vkey;
        w_rank   = r_rank;
        w_idx    = r_idx;
        w_cnt    = r_cnt;
        w_victim = r_victim;
        w_steal  = 1'b0;
        if (!Enable) begin
            w_on    = '0;
            w_state = SCAN;
        end else if (r_state == SCAN) begin
            if (w_key && !(|w_match)) begin
                if (!(&r_on)) begin
                    w_on[w_free_v]   = 1'b1;
                    w_vkey[w_free_v] = r_idx;
                    w_rank           = lru_touch(r_rank, w_free_v);
                    w_idx            = r_idx + 3'd1;
                end else begin
                    w_on[w_oldest] = 1'b0;
                    w_victim       = w_oldest;
                    w_steal        = 1'b1;
                    w_cnt          = 4'(STEAL_GAP - 1);
                    w_state        = GAP;
                end
            end else begin
                if (!w_key && (|w_match)) w_on[w_hit_v] = 1'b0;
                w_idx = r_idx + 3'd1;
            end
        end else begin
            if (r_cnt == 4'd0) begin
                if (w_key) begin
                    w_on[r_victim]   = 1'b1;
                    w_vkey[r_victim] = r_idx;
                    w_rank           = lru_touch(r_rank, r_victim);
                end
                w_idx   = r_idx + 3'd1;
                w_state = SCAN;
            end else begin
                w_cnt = r_cnt - 4'd1;
            end
        end
        w_all_busy = &w_on;
    end

    // State register with synchronous active-low reset; reset abandons any steal in progress
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state    <= SCAN;
            r_on       <= '0;
            r_vkey     <= '0;
            r_rank     <= {2'd3, 2'd2, 2'd1, 2'd0};
            r_idx      <= '0;
            r_cnt      <= '0;
            r_victim   <= '0;
            r_steal    <= 1'b0;
            r_all_busy <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_on       <= w_on;
            r_vkey     <= w_vkey;
            r_rank     <= w_rank;
            r_idx      <= w_idx;
            r_cnt      <= w_cnt;
            r_victim   <= w_victim;
            r_steal    <= w_steal;
            r_all_busy <= w_all_busy;
        end
    end

    assign voice_on  = r_on;
    assign voice_key = r_vkey;
    assign steal     = r_steal;
    assign all_busy  = r_all_busy;
endmodule
